// File: rtl/code_readback.sv
// Program-RAM readback: pulls single code words into byte registers or scans the whole RAM into a checksum.
// Define READBACK_CRC_EN to replace the modular-sum checksum with CRC-16-CCITT.
module code_readback #(
  parameter int unsigned ADDR_W        = 7,
  parameter logic [7:0]  CMD_NOP       = 8'd0,
  parameter logic [7:0]  CMD_INIT_RD   = 8'd5,
  parameter logic [7:0]  CMD_PULL_CODE = 8'd6,
  parameter logic [7:0]  CMD_CHECKSUM  = 8'd7
) (
  input  logic              mclk,
  input  logic              reset,
  input  logic [7:0]        cmd,
  output logic              re,
  output logic [ADDR_W-1:0] raddr,
  input  logic [31:0]       rdata,
  output logic [7:0]        rd_b0,
  output logic [7:0]        rd_b1,
  output logic [7:0]        rd_b2,
  output logic [7:0]        rd_b3,
  output logic [15:0]       csum,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    SUM_RUN,
    SUM_DRAIN,
    WAIT_CLEAR
  } state_t;

`ifdef READBACK_CRC_EN
  localparam logic [15:0] SEED = 16'hFFFF;

  // Bit-serial CRC over all 32 bits MSB first equals byte-wise processing, MSB byte first.
  function automatic logic [15:0] fold(input logic [15:0] acc_in, input logic [31:0] w);
    logic [15:0] c;
    c = acc_in;
    for (int unsigned i = 0; i < 32; i++) begin
      if (c[15] ^ w[31-i])
        c = {c[14:0], 1'b0} ^ 16'h1021;
      else
        c = {c[14:0], 1'b0};
    end
    return c;
  endfunction
`else
  localparam logic [15:0] SEED = 16'h0000;

  function automatic logic [15:0] fold(input logic [15:0] acc_in, input logic [31:0] w);
    return acc_in + w[31:16] + w[15:0];
  endfunction
`endif

  state_t            state;
  logic [ADDR_W-1:0] rptr;
  logic [15:0]       acc;
  logic              last_pull;

  always_ff @(posedge mclk) begin
    if (reset) begin
      state     <= IDLE;
      re        <= 1'b0;
      raddr     <= '0;
      rptr      <= '0;
      acc       <= SEED;
      last_pull <= 1'b0;
      rd_b0     <= '0;
      rd_b1     <= '0;
      rd_b2     <= '0;
      rd_b3     <= '0;
      csum      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          case (cmd)
            CMD_INIT_RD: begin
              rptr      <= '0;
              last_pull <= 1'b0;
              done      <= 1'b1;
              state     <= WAIT_CLEAR;
            end
            CMD_PULL_CODE: begin
              re        <= 1'b1;
              raddr     <= rptr;
              busy      <= 1'b1;
              last_pull <= 1'b1;
              state     <= RD_WAIT;
            end
            CMD_CHECKSUM: begin
              re        <= 1'b1;
              raddr     <= '0;
              acc       <= SEED;
              busy      <= 1'b1;
              last_pull <= 1'b0;
              state     <= SUM_RUN;
            end
            default: ;
          endcase
        end

        // First cycle drops re; rdata is valid on the following cycle (re already low).
        RD_WAIT: begin
          if (re) begin
            re <= 1'b0;
          end else begin
            rd_b0 <= rdata[31:24];
            rd_b1 <= rdata[23:16];
            rd_b2 <= rdata[15:8];
            rd_b3 <= rdata[7:0];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= WAIT_CLEAR;
          end
        end

        // raddr==0 only on the first scan cycle, when no read data is available yet.
        SUM_RUN: begin
          if (raddr != '0)
            acc <= fold(acc, rdata);
          if (raddr == '1) begin
            re    <= 1'b0;
            state <= SUM_DRAIN;
          end else begin
            raddr <= raddr + ADDR_W'(1);
          end
        end

        SUM_DRAIN: begin
          csum  <= fold(acc, rdata);
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= WAIT_CLEAR;
        end

        WAIT_CLEAR: begin
          if (cmd == CMD_NOP) begin
            done      <= 1'b0;
            last_pull <= 1'b0;
            if (last_pull)
              rptr <= rptr + ADDR_W'(1);
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_code_readback.sv
// Directed bench for code_readback: pull timing, pointer wrap, scan latency/checksum, reset abort.
module tb_code_readback;
  localparam int unsigned AW    = 7;
  localparam int unsigned DEPTH = 128;

  logic          mclk = 1'b0;
  logic          reset;
  logic [7:0]    cmd;
  logic          re;
  logic [AW-1:0] raddr;
  logic [31:0]   rdata;
  logic [7:0]    b0, b1, b2, b3;
  logic [15:0]   csum;
  logic          busy, done;

  logic [31:0]   mem [DEPTH];
  int            total = 0;
  int            bad   = 0;

  code_readback #(.ADDR_W(AW)) dut (
    .mclk  (mclk),
    .reset (reset),
    .cmd   (cmd),
    .re    (re),
    .raddr (raddr),
    .rdata (rdata),
    .rd_b0 (b0),
    .rd_b1 (b1),
    .rd_b2 (b2),
    .rd_b3 (b3),
    .csum  (csum),
    .busy  (busy),
    .done  (done)
  );

  always #5 mclk = ~mclk;

  // Synchronous program RAM: data valid the cycle after re.
  always_ff @(posedge mclk)
    if (re) rdata <= mem[raddr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic fill_const(input logic [31:0] v);
    for (int i = 0; i < DEPTH; i++) mem[i] = v;
  endtask

  task automatic fill_index();
    for (int i = 0; i < DEPTH; i++) mem[i] = i;
  endtask

  // Byte-wise CRC-16-CCITT reference over the RAM image, MSB byte of each word first.
  function automatic logic [15:0] ref_crc();
    logic [15:0] c;
    logic [7:0]  by;
    logic [31:0] w;
    c = 16'hFFFF;
    for (int i = 0; i < DEPTH; i++) begin
      w = mem[i];
      for (int k = 3; k >= 0; k--) begin
        by = w[8*k +: 8];
        c  = c ^ {by, 8'h00};
        for (int j = 0; j < 8; j++)
          c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
      end
    end
    return c;
  endfunction

  task automatic pull(output logic [31:0] w, output logic [AW-1:0] a);
    cmd = 8'd6;
    tick();
    a = raddr;
    tick();
    tick();
    w = {b0, b1, b2, b3};
    cmd = 8'd0;
    tick();
  endtask

  task automatic run_scan(input string tag, input logic [15:0] exp);
    int   idx;
    logic prev_busy;
    cmd = 8'd7;
    tick();
    chk({tag, "_t1_re"}, re, 1'b1);
    chk({tag, "_t1_raddr"}, raddr, 0);
    idx = 1;
    prev_busy = busy;
    while (!done && idx < 300) begin
      prev_busy = busy;
      tick();
      idx++;
    end
    chk({tag, "_done_cycle"}, idx, 130);
    chk({tag, "_busy_before_done"}, prev_busy, 1'b1);
    chk({tag, "_busy_at_done"}, busy, 1'b0);
    chk({tag, "_csum"}, csum, exp);
    cmd = 8'd0;
    tick();
    chk({tag, "_done_clr"}, done, 1'b0);
  endtask

  initial begin
    logic [31:0]   w;
    logic [AW-1:0] a;
    int            pulses;
    logic          any;

    reset = 1'b1;
    cmd   = 8'd0;
    fill_const(32'h0);
    repeat (3) tick();
    chk("rst_re", re, 1'b0);
    chk("rst_raddr", raddr, 0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_csum", csum, 16'h0);
    chk("rst_bytes", {b0, b1, b2, b3}, 32'h0);
    reset = 1'b0;
    tick();

    // Single pull with held command
    mem[0] = 32'h12345678;
    mem[1] = 32'h9ABCDEF0;
    cmd = 8'd6;
    tick();
    chk("pull_t1_re", re, 1'b1);
    chk("pull_t1_raddr", raddr, 0);
    chk("pull_t1_busy", busy, 1'b1);
    pulses = 1;
    tick();
    chk("pull_t2_re", re, 1'b0);
    chk("pull_t2_done", done, 1'b0);
    tick();
    chk("pull_t3_bytes", {b0, b1, b2, b3}, 32'h12345678);
    chk("pull_t3_done", done, 1'b1);
    chk("pull_t3_busy", busy, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tick();
      if (re) pulses++;
    end
    chk("held_cmd_pulses", pulses, 1);
    cmd = 8'd0;
    tick();
    chk("nop_done_clr", done, 1'b0);
    pull(w, a);
    chk("pull2_raddr", a, 1);
    chk("pull2_word", w, 32'h9ABCDEF0);

    // Loader commands are ignored
    any = 1'b0;
    cmd = 8'd3;
    for (int i = 0; i < 5; i++) begin
      tick();
      any = any | re | busy | done;
    end
    chk("loader_cmd_ignored", any, 1'b0);
    cmd = 8'd0;
    tick();

    // Init pointer then walk all words and wrap
    cmd = 8'd5;
    tick();
    chk("init_done", done, 1'b1);
    cmd = 8'd0;
    tick();
    chk("init_done_clr", done, 1'b0);
    fill_index();
    for (int i = 0; i < DEPTH; i++) begin
      pull(w, a);
      if (i == 0) chk("walk_first", w, 0);
    end
    chk("walk_last_word", w, 127);
    chk("walk_last_addr", a, 127);
    pull(w, a);
    chk("wrap_raddr", a, 0);
    chk("wrap_word", w, 0);

    // Scans
    fill_const(32'hFFFFFFFF);
`ifdef READBACK_CRC_EN
    run_scan("scan_ff", ref_crc());
`else
    run_scan("scan_ff", 16'hFF00);
`endif
    fill_const(32'h0);
`ifdef READBACK_CRC_EN
    run_scan("scan_zero", ref_crc());
`else
    run_scan("scan_zero", 16'h0000);
`endif
    fill_index();
`ifdef READBACK_CRC_EN
    run_scan("scan_idx", ref_crc());
`else
    run_scan("scan_idx", 16'h1FC0);
`endif
    pull(w, a);
    chk("scan_keeps_rptr", a, 1);

    // Reset in the middle of a scan
    fill_const(32'hFFFFFFFF);
    cmd = 8'd7;
    tick();
    for (int i = 1; i < 40; i++) tick();
    chk("abort_busy_pre", busy, 1'b1);
    reset = 1'b1;
    cmd   = 8'd0;
    tick();
    chk("abort_re", re, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_csum", csum, 16'h0);
    reset = 1'b0;
    tick();
    fill_index();
`ifdef READBACK_CRC_EN
    run_scan("scan_after_abort", ref_crc());
`else
    run_scan("scan_after_abort", 16'h1FC0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
